// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle core front end.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package core_pkg;

    localparam int INST_W = 32;

    typedef logic [2:0] phase_t;

    // Phase in which instruction memory samples pc, and the phase in which
    // the registered memory word is captured into ir.
    localparam phase_t PHASE_FETCH   = 3'd0;
    localparam phase_t PHASE_CAPTURE = 3'd1;

    localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_next_pc.sv
// Next fetch address selection (redirect or sequential +4) and its legality.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module if_next_pc
    import core_pkg::*;
#(
    parameter int IM_BYTES = 512
) (
    input  logic [INST_W-1:0] pc,
    input  logic              redirect_valid,
    input  logic [INST_W-1:0] redirect_target,
    output logic [INST_W-1:0] next_pc,
    output logic              illegal
);

    localparam logic [INST_W-1:0] IM_LIMIT = INST_W'(IM_BYTES);

    // Pick the candidate and flag misaligned or out-of-memory addresses.
    always_comb begin
        next_pc = redirect_valid ? redirect_target : pc + 32'd4;
        illegal = (next_pc[1:0] != 2'b00) || (next_pc >= IM_LIMIT);
    end

endmodule

// File: rtl/if_sequencer.sv
// Instruction-fetch initiator: owns pc and phase counter, captures ir.
// Latency: ir/ir_pc/ir_valid update 2 clocks after counter reaches 0.
// Backpressure: stall freezes counter, pc, ir, ir_pc, ir_valid and fetch_err.
module if_sequencer
    import core_pkg::*;
#(
    parameter int                NUM_PHASES = 5,
    parameter logic [INST_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int                IM_BYTES   = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [INST_W-1:0] redirect_target,
    input  logic [INST_W-1:0] inst_in,
    output logic [INST_W-1:0] pc,
    output logic [2:0]        counter,
    output logic [INST_W-1:0] ir,
    output logic [INST_W-1:0] ir_pc,
    output logic              ir_valid,
    output logic              fetch_err
);

    localparam phase_t PHASE_LAST = phase_t'(NUM_PHASES - 1);

    logic [INST_W-1:0] next_pc;
    logic              next_illegal;

    if_next_pc #(
        .IM_BYTES (IM_BYTES)
    ) u_next_pc (
        .pc              (pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .next_pc         (next_pc),
        .illegal         (next_illegal)
    );

    // Phase sequencing, instruction capture and pc update; an illegal next
    // address keeps pc so the same instruction is refetched while the sticky
    // error tells the core to halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter   <= PHASE_FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            ir_pc     <= '0;
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
        end else if (!stall) begin
            counter <= (counter == PHASE_LAST) ? PHASE_FETCH : counter + 3'd1;

            if (counter == PHASE_CAPTURE) begin
                ir       <= inst_in;
                ir_pc    <= pc;
                ir_valid <= 1'b1;
            end

            if (counter == PHASE_LAST) begin
                if (next_illegal) begin
                    fetch_err <= 1'b1;
                end else begin
                    pc <= next_pc;
                end
            end
        end
    end

endmodule

// File: doc/if_sequencer.md
Name: if_sequencer

Overview:
- Initiator side of the instruction-memory fetch interface.
- Owns the program counter and the multi-cycle phase counter that the instruction memory samples. It drives pc/counter, captures the registered instruction word one phase later into an instruction register, and sequences PC update (+4 or redirect).
- Sits between the instruction memory and the decode/execute/writeback phases of the multi-cycle core.

Parameters:
- NUM_PHASES, 5, phases per instruction; counter runs 0..NUM_PHASES-1 (legal range 2..8).
- RESET_PC, 32'h0000_0000, PC value after reset.
- IM_BYTES, 512, instruction-memory span in bytes; fetch PC must be < IM_BYTES.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- stall  in  1  freeze all state (counter, pc, ir) this cycle.
- redirect_valid  in  1  branch/jump taken; sampled only when counter==NUM_PHASES-1.
- redirect_target  in  32  next PC when redirect_valid accepted.
- inst_in  in  32  registered instruction word from instruction memory.
- pc  out  32  fetch address to instruction memory (byte address, word-aligned).
- counter  out  3  current phase; instruction memory reads when counter==0.
- ir  out  32  captured instruction register.
- ir_pc  out  32  PC of the instruction held in ir.
- ir_valid  out  1  ir holds a fetched instruction.
- fetch_err  out  1  sticky error: misaligned or out-of-range PC.

Behaviour:
- Reset (rst=1 at posedge; overrides stall): pc=RESET_PC, counter=0, ir=0, ir_pc=0, ir_valid=0, fetch_err=0.
- Phase counter:
  - Increments each unstalled cycle and wraps NUM_PHASES-1 -> 0.
  - With stall=1, counter, pc, ir, ir_pc, ir_valid and fetch_err all hold.
- Fetch timing:
  - Memory registers inst at the posedge where counter==0.
  - On the unstalled posedge where counter==1: ir<=inst_in, ir_pc<=pc, ir_valid<=1.
  - Fetch-to-ir latency is 2 clocks from counter reaching 0.
  - ir_valid stays 1 thereafter until reset.
- pc stability: pc is constant from the counter==0 edge until the last phase, so the memory never sees a changing address mid-instruction.
- PC update, on the unstalled posedge where counter==NUM_PHASES-1:
  - redirect_valid=1 and target legal -> pc<=redirect_target.
  - redirect_valid=0 -> pc<=pc+4, 32-bit wrap modulo 2^32.
  - redirect_valid is ignored in every other phase.
- Legality of a candidate next PC: bits[1:0]==0 and value < IM_BYTES.
- Illegal next PC (redirect or +4):
  - pc holds its current value and fetch_err<=1.
  - counter continues and the same instruction is refetched. The core is expected to halt on fetch_err.
  - fetch_err clears only on reset.
- Simultaneous stall and redirect in the last phase: stall wins; redirect is re-sampled next unstalled cycle while counter is still NUM_PHASES-1.
- Reset mid-instruction: phase and ir are discarded; the next instruction fetch is at RESET_PC with counter=0.
- counter output width is 3 bits; upper bits are zero when NUM_PHASES<8.

Decomposition:
- Shared package core_pkg:
  - PHASE_FETCH=0, PHASE_CAPTURE=1 constants.
  - phase_t (3-bit) typedef.
  - INST_W=32.
  - RESET_PC default.
- Sub-module: if_next_pc, combinational. Computes next-PC selection and legality (inputs pc, redirect_valid, redirect_target; outputs next_pc, illegal).
- Phase counter and registers stay in the top module.

Test Plan:
- Reset then 10 unstalled cycles, memory word at 0 = 32'h0000_0013 -> ir=32'h13, ir_pc=0, ir_valid=1 at cycle 2; pc=4 after cycle 5; counter sequence 0,1,2,3,4,0.
- redirect_valid=1, target=32'h40, asserted in phase 2 only -> ignored, pc=4. Asserted in phase 4 -> pc=32'h40 next cycle; next ir_pc=32'h40.
- stall=1 for 3 cycles starting in phase 1 -> counter, pc, ir held for 3 cycles; capture occurs on first unstalled edge; total instruction takes 8 clocks.
- Redirect target=32'h42 in phase 4 -> fetch_err=1, pc unchanged. With IM_BYTES=512, sequential run from pc=32'h1FC -> +4 gives 512, so fetch_err=1 and pc stays 32'h1FC.
- stall=1 and rst=1 together mid phase 3 -> all outputs at reset values next cycle; ir_valid=0; fetch_err cleared.
- Back-to-back 128-instruction run, stall randomly 20% -> ir_pc increments by 4 each instruction, no instruction skipped or duplicated, ir matches memory image.
